// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder.
// Direct mode decodes the index on n. Scan mode steps an internal index
// through every output at one step per PRESCALE enabled cycles and pulses
// wrap when the index rolls over from its top value to zero.
module decoder_scan #(
  parameter int N        = 3,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                ena,
  input  logic                mode,
  input  logic [N-1:0]        n,
  input  logic                load,
  output logic [(1<<N)-1:0]   d,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int W  = 1 << N;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

  logic [W-1:0]  d_q,    d_d;
  logic [N-1:0]  idx_q,  idx_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] pc_q,   pc_d;
  logic          mode_q;

  // Next-state selection; the if-chain order is the priority order of the
  // update rules, so a load always beats a step landing on the same edge.
  always_comb begin
    idx_d  = idx_q;
    pc_d   = pc_q;
    wrap_d = 1'b0;
    d_d    = '0;
    if (!ena) begin
      idx_d = idx_q;
      pc_d  = pc_q;
    end else if (!mode) begin
      idx_d = n;
      pc_d  = '0;
    end else if (!mode_q) begin
      idx_d = idx_q;
      pc_d  = '0;
    end else if (load) begin
      idx_d = n;
      pc_d  = '0;
    end else if (pc_q == PC_LAST) begin
      idx_d  = idx_q + 1'b1;
      pc_d   = '0;
      wrap_d = &idx_q;
    end else begin
      pc_d = pc_q + 1'b1;
    end
    if (ena) begin
      d_d = W'(1) << idx_d;
    end
  end

  // State and output registers; the mode copy tracks mode even while disabled
  // so a mode entry seen with ena low is consumed rather than deferred.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      d_q    <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      pc_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      pc_q   <= pc_d;
      mode_q <= mode;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Testbench for decoder_scan: a table of direct-mode vectors plus hand-built
// scan sequences, with expectations queued per edge and popped once the
// outputs have settled after that edge. A second instance runs PRESCALE=1.
module tb_decoder_scan;

  logic       clk;
  logic       clrn;
  logic       ena;
  logic       mode;
  logic [2:0] n;
  logic       load;
  logic [7:0] d0, d1;
  logic [2:0] idx0, idx1;
  logic       wrap0, wrap1;

  int compared;
  int mismatched;

  typedef struct {
    logic       ena;
    logic       mode;
    logic [2:0] n;
    logic       load;
    logic [7:0] expD;
    logic [2:0] expIdx;
    logic       expWrap;
  } vec_t;

  typedef struct {
    bit         which;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
    string      tag;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];

  decoder_scan #(.N(3), .PRESCALE(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .ena  (ena),
    .mode (mode),
    .n    (n),
    .load (load),
    .d    (d0),
    .idx  (idx0),
    .wrap (wrap0)
  );

  decoder_scan #(.N(3), .PRESCALE(1)) dutFast (
    .clk  (clk),
    .clrn (clrn),
    .ena  (ena),
    .mode (mode),
    .n    (n),
    .load (load),
    .d    (d1),
    .idx  (idx1),
    .wrap (wrap1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a broken run can never hang the simulator.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want summary before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic e, input logic m, input logic [2:0] nn, input logic l);
    ena  = e;
    mode = m;
    n    = nn;
    load = l;
  endtask

  task automatic pushExpect(input bit which, input logic [7:0] ed, input logic [2:0] ei,
                            input logic ew, input string tag);
    exp_t e;
    e.which = which;
    e.d     = ed;
    e.idx   = ei;
    e.wrap  = ew;
    e.tag   = tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [7:0] ad;
    logic [2:0] ai;
    logic       aw;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.which) begin
        ad = d1; ai = idx1; aw = wrap1;
      end else begin
        ad = d0; ai = idx0; aw = wrap0;
      end
      compared++;
      if (ad !== e.d || ai !== e.idx || aw !== e.wrap) begin
        mismatched++;
        $display("[TB] FAIL %s: got d=%h idx=%0d wrap=%b, want d=%h idx=%0d wrap=%b",
                 e.tag, ad, ai, aw, e.d, e.idx, e.wrap);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Called 1 time unit after an edge: pulse reset between edges, check the
  // immediate clear and that values hold after release until the next edge.
  task automatic doReset(input string tag);
    #2;
    clrn = 1'b0;
    #1;
    pushExpect(0, 8'h00, 3'd0, 1'b0, {tag, "_async"});
    pushExpect(1, 8'h00, 3'd0, 1'b0, {tag, "_async_fast"});
    checkOutput();
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
    #1;
    clrn = 1'b1;
    #1;
    pushExpect(0, 8'h00, 3'd0, 1'b0, {tag, "_hold"});
    checkOutput();
  endtask

  initial begin
    logic [7:0] ed;
    int         ix;

    compared   = 0;
    mismatched = 0;
    clrn       = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);

    vecs[0] = '{1'b1, 1'b0, 3'd5, 1'b0, 8'h20, 3'd5, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 3'd5, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 3'd5, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 3'd2, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'd7, 1'b0, 8'h80, 3'd7, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 3'd3, 1'b0, 8'h08, 3'd3, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 3'd6, 1'b1, 8'h40, 3'd6, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 3'd4, 1'b0, 8'h10, 3'd4, 1'b0};

    @(posedge clk);
    #1;
    pushExpect(0, 8'h00, 3'd0, 1'b0, "reset_state");
    checkOutput();
    clrn = 1'b1;

    // Direct decode table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ena, vecs[i].mode, vecs[i].n, vecs[i].load);
      pushExpect(0, vecs[i].expD, vecs[i].expIdx, vecs[i].expWrap, $sformatf("direct_%0d", i));
      tick();
    end

    // Scan from reset: entry edge then a step every 4 edges, one wrap.
    doReset("scan_reset");
    for (int k = 0; k <= 43; k++) begin
      ix = (k / 4) % 8;
      ed = 8'h01 << ix;
      pushExpect(0, ed, 3'(ix), (k > 0 && k % 4 == 0 && ix == 0), $sformatf("scan_%0d", k));
      tick();
    end

    // Load on the same edge a step is due: load wins, interval restarts.
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1);
    pushExpect(0, 8'h08, 3'd3, 1'b0, "load_beats_step");
    tick();
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pushExpect(0, 8'h08, 3'd3, 1'b0, $sformatf("after_load_hold_%0d", k));
      tick();
    end
    pushExpect(0, 8'h10, 3'd4, 1'b0, "after_load_step");
    tick();
    for (int k = 0; k < 2; k++) begin
      pushExpect(0, 8'h10, 3'd4, 1'b0, $sformatf("pre_freeze_%0d", k));
      tick();
    end

    // Freeze with the prescaler at 2, then resume.
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      pushExpect(0, 8'h00, 3'd4, 1'b0, $sformatf("freeze_%0d", k));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
    pushExpect(0, 8'h10, 3'd4, 1'b0, "resume_hold");
    tick();
    pushExpect(0, 8'h20, 3'd5, 1'b0, "resume_step");
    tick();
    for (int k = 0; k < 3; k++) begin
      pushExpect(0, 8'h20, 3'd5, 1'b0, $sformatf("resume_run_%0d", k));
      tick();
    end
    pushExpect(0, 8'h40, 3'd6, 1'b0, "reach_idx6");
    tick();
    pushExpect(0, 8'h40, 3'd6, 1'b0, "idx6_hold");
    tick();

    // Asynchronous reset mid-scan, then a clean restart with a full interval.
    doReset("midscan_reset");
    for (int k = 0; k <= 4; k++) begin
      ix = k / 4;
      ed = 8'h01 << ix;
      pushExpect(0, ed, 3'(ix), 1'b0, $sformatf("restart_%0d", k));
      tick();
    end

    // PRESCALE=1 instance: a step on every enabled edge, wrap every 8.
    doReset("fast_reset");
    for (int k = 0; k <= 17; k++) begin
      ix = k % 8;
      ed = 8'h01 << ix;
      pushExpect(1, ed, 3'(ix), (k > 0 && ix == 0), $sformatf("fast_%0d", k));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
